// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer that sits between the CPU datapath
// and the word-indexed data memory.
package store_buffer_pkg;

  localparam int WORD_W       = 32;
  localparam int SB_ADDR_W    = 6;
  localparam int SB_DEPTH     = 4;
  localparam int SB_STALL_MAX = 8;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]    data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// CPU store/load handshakes plus the single data_memory port, bundled for the store buffer.
// The master side is the CPU/memory environment; the slave side is the store buffer.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              st_valid;
  logic              st_ready;
  logic [WORD_W-1:0] st_addr;
  logic [WORD_W-1:0] st_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [WORD_W-1:0] ld_addr;
  logic [WORD_W-1:0] ld_data;
  logic              mem_write_enable;
  logic [WORD_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_write_data;
  logic [WORD_W-1:0] mem_read_data;
  logic              empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
    input  st_ready, ld_ready, ld_data, mem_write_enable, mem_address,
           mem_write_data, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
    output st_ready, ld_ready, ld_data, mem_write_enable, mem_address,
           mem_write_data, empty, count
  );

endinterface

// File: rtl/store_buffer.sv
// Word-granular store buffer: queues CPU stores, drains one per idle memory-port cycle,
// and forwards the youngest buffered word to loads that hit it.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = SB_DEPTH,
  parameter int ADDR_W    = SB_ADDR_W,
  parameter int STALL_MAX = SB_STALL_MAX
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STL_W = $clog2(STALL_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [STL_W-1:0] STALL_LAST = STL_W'(STALL_MAX - 1);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [WORD_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [STL_W-1:0]  r_stall_cnt;

  logic              w_full;
  logic              w_empty;
  logic              w_force;
  logic              w_ld_take;
  logic              w_push;
  logic              w_pop;
  logic [DEPTH-1:0]  w_hit;
  logic [WORD_W-1:0] w_slot_data [DEPTH];
  logic              w_fwd_hit;
  logic [WORD_W-1:0] w_fwd_data;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_force   = (r_stall_cnt == STALL_LAST);
  assign w_ld_take = bus.ld_valid && !w_force;
  assign w_push    = bus.st_valid && !w_full;
  // Memory writes are suppressed while reset is held so a mid-drain reset commits nothing.
  assign w_pop     = rst_n && !w_ld_take && !w_empty;

  // Slot gi is the gi-th oldest live entry; later slots are younger.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] w_idx;
    assign w_idx            = r_rd_ptr + PTR_W'(gi);
    assign w_hit[gi]        = (CNT_W'(gi) < r_count) &&
                              (r_addr[w_idx] == bus.ld_addr[ADDR_W-1:0]);
    assign w_slot_data[gi]  = r_data[w_idx];
  end

  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_hit[i]) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_slot_data[i];
      end
    end
  end

  assign bus.st_ready         = !w_full;
  assign bus.ld_ready         = !w_force;
  assign bus.empty            = w_empty;
  assign bus.count            = r_count;
  assign bus.mem_write_enable = w_pop;
  assign bus.mem_address      = w_pop ? {{(WORD_W-ADDR_W){1'b0}}, r_addr[r_rd_ptr]}
                                      : bus.ld_addr;
  assign bus.mem_write_data   = r_data[r_rd_ptr];
  assign bus.ld_data          = w_fwd_hit ? w_fwd_data : bus.mem_read_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_force)
        r_stall_cnt <= '0;
      else if (w_full && bus.ld_valid)
        r_stall_cnt <= r_stall_cnt + STL_W'(1);
      else
        r_stall_cnt <= '0;
    end
  end

  // Entry storage carries no reset; only the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= bus.st_addr[ADDR_W-1:0];
      r_data[r_wr_ptr] <= bus.st_data;
    end
  end

endmodule
